// File: rtl/conv_n_a_m.sv
// conv_n_a_m : packs RATIO narrow lanes of IN_W bits into one OUT_W-bit word.
//
// Lanes are collected in an accumulator. When the last lane of a word is
// accepted (lane counter at RATIO-1, or in_last), the word moves into a
// one-word output buffer. The accumulator keeps filling while the buffer
// waits downstream. Only the lane that would close the next word stalls.
//
// Parameters
//   IN_W      : input lane width in bits
//   RATIO     : lanes per output word (>= 2)
//   MSB_FIRST : 1 = first lane lands in the top lane of out_data,
//               0 = first lane lands in out_data[IN_W-1:0]
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous reset, active low
//   in_valid   : in_data holds a lane this cycle
//   in_data    : input lane
//   in_last    : together with in_valid, this lane closes the word
//   in_ready   : a lane is accepted this cycle (combinational)
//   out_valid  : out_data/out_keep hold a word
//   out_data   : packed word
//   out_keep   : one bit per lane, 1 = lane carries data (same order as lanes)
//   out_ready  : downstream takes the word
//   out_par    : per-lane even parity of out_data (only with CONV_PAR_EN)
//
// Optional build macro: CONV_PAR_EN adds the out_par output.
module conv_n_a_m #(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 1,
  localparam int OUT_W    = IN_W * RATIO
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [RATIO-1:0] out_keep,
`ifdef CONV_PAR_EN
  output logic [RATIO-1:0] out_par,
`endif
  input  logic             out_ready
);

  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic [CW-1:0]    cnt_p0;
  logic [OUT_W-1:0] acc_p0;
  logic [RATIO-1:0] keep_p0;

  logic [CW-1:0]    pos;
  logic             close_pending;
  logic             accept;
  logic             close;
  logic             drain;
  logic [OUT_W-1:0] acc_nxt;
  logic [RATIO-1:0] keep_nxt;

`ifdef CONV_PAR_EN
  function automatic logic [RATIO-1:0] lane_par(input logic [OUT_W-1:0] w);
    logic [RATIO-1:0] p;
    p = '0;
    for (int i = 0; i < RATIO; i++) p[i] = ^w[i*IN_W +: IN_W];
    return p;
  endfunction
`endif

  // Lane placement and the next accumulator contents if this lane is accepted
  always_comb begin
    pos           = (MSB_FIRST != 0) ? (CW'(RATIO - 1) - cnt_p0) : cnt_p0;
    close_pending = (cnt_p0 == CW'(RATIO - 1)) | in_last;
    acc_nxt       = acc_p0;
    keep_nxt      = keep_p0;
    for (int i = 0; i < RATIO; i++) begin
      if (CW'(i) == pos) begin
        acc_nxt[i*IN_W +: IN_W] = in_data;
        keep_nxt[i]             = 1'b1;
      end
    end
  end

  // A closing lane is held off only when the buffer is full and cannot drain
  assign in_ready = !((state == FULL) & !out_ready & close_pending);
  assign accept   = in_valid & in_ready;
  assign close    = accept & close_pending;
  assign drain    = out_valid & out_ready;

  // Stage p0: accumulator, then output buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      cnt_p0    <= '0;
      acc_p0    <= '0;
      keep_p0   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
`ifdef CONV_PAR_EN
      out_par   <= '0;
`endif
    end else begin
      if (accept) begin
        if (close) begin
          cnt_p0  <= '0;
          acc_p0  <= '0;
          keep_p0 <= '0;
        end else begin
          cnt_p0  <= cnt_p0 + 1'b1;
          acc_p0  <= acc_nxt;
          keep_p0 <= keep_nxt;
        end
      end

      // A close while FULL implies out_ready, so it always coincides with a drain
      if (close) begin
        state     <= FULL;
        out_valid <= 1'b1;
        out_data  <= acc_nxt;
        out_keep  <= keep_nxt;
`ifdef CONV_PAR_EN
        out_par   <= lane_par(acc_nxt);
`endif
      end else if (state == FULL && drain) begin
        state     <= EMPTY;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_n_a_m.sv
module tb_conv_n_a_m;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_m, in_ready_l;
  logic        out_valid_m, out_valid_l;
  logic [31:0] data_m, data_l;
  logic [3:0]  keep_m, keep_l;
`ifdef CONV_PAR_EN
  logic [3:0]  par_m, par_l;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv_n_a_m #(.IN_W(8), .RATIO(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready_m), .out_valid(out_valid_m),
    .out_data(data_m), .out_keep(keep_m),
`ifdef CONV_PAR_EN
    .out_par(par_m),
`endif
    .out_ready(out_ready));

  conv_n_a_m #(.IN_W(8), .RATIO(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready_l), .out_valid(out_valid_l),
    .out_data(data_l), .out_keep(keep_l),
`ifdef CONV_PAR_EN
    .out_par(par_l),
`endif
    .out_ready(out_ready));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
    reset = 1'b0;
    step(); step();
    total++; if (out_valid_m !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid_m); end
    total++; if (data_m !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=00000000", data_m); end
    total++; if (keep_m !== 4'b0) begin bad++; $display("FAIL reset_keep got=%b want=0000", keep_m); end
    reset = 1'b1;
    #1;
    total++; if (in_ready_m !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready_m); end
  endtask

  task automatic test_full_word();
    send(8'h0F, 1'b0);
    send(8'h0D, 1'b0);
    send(8'h03, 1'b0);
    total++; if (out_valid_m !== 1'b0) begin bad++; $display("FAIL full_early_valid got=%b want=0", out_valid_m); end
    send(8'hAA, 1'b0);
    total++; if (out_valid_m !== 1'b1) begin bad++; $display("FAIL full_valid got=%b want=1", out_valid_m); end
    total++; if (data_m !== 32'h0F0D03AA) begin bad++; $display("FAIL full_data got=%h want=0f0d03aa", data_m); end
    total++; if (keep_m !== 4'b1111) begin bad++; $display("FAIL full_keep got=%b want=1111", keep_m); end
    total++; if (data_l !== 32'hAA030D0F) begin bad++; $display("FAIL lsb_data got=%h want=aa030d0f", data_l); end
    total++; if (keep_l !== 4'b1111) begin bad++; $display("FAIL lsb_keep got=%b want=1111", keep_l); end
`ifdef CONV_PAR_EN
    // lanes 0x0F,0x0D,0x03,0xAA -> XOR-reduce 0,1,0,0 placed MSB-first
    total++; if (par_m !== 4'b0100) begin bad++; $display("FAIL par_msb got=%b want=0100", par_m); end
    total++; if (par_l !== 4'b0010) begin bad++; $display("FAIL par_lsb got=%b want=0010", par_l); end
`endif
    step();
    total++; if (out_valid_m !== 1'b0) begin bad++; $display("FAIL full_one_cycle got=%b want=0", out_valid_m); end
  endtask

  task automatic test_partial_flush();
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    total++; if (out_valid_m !== 1'b1) begin bad++; $display("FAIL part_valid got=%b want=1", out_valid_m); end
    total++; if (data_m !== 32'h11220000) begin bad++; $display("FAIL part_data got=%h want=11220000", data_m); end
    total++; if (keep_m !== 4'b1100) begin bad++; $display("FAIL part_keep got=%b want=1100", keep_m); end
    total++; if (data_l !== 32'h00002211) begin bad++; $display("FAIL part_lsb_data got=%h want=00002211", data_l); end
    total++; if (keep_l !== 4'b0011) begin bad++; $display("FAIL part_lsb_keep got=%b want=0011", keep_l); end
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    total++; if (data_m !== 32'h33445566) begin bad++; $display("FAIL part_next_data got=%h want=33445566", data_m); end
    total++; if (keep_m !== 4'b1111) begin bad++; $display("FAIL part_next_keep got=%b want=1111", keep_m); end
    // lone in_last at lane 0
    send(8'h77, 1'b1);
    total++; if (data_m !== 32'h77000000) begin bad++; $display("FAIL lone_last_data got=%h want=77000000", data_m); end
    total++; if (keep_m !== 4'b1000) begin bad++; $display("FAIL lone_last_keep got=%b want=1000", keep_m); end
    step();
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    total++; if (data_m !== 32'h01020304) begin bad++; $display("FAIL bp_first got=%h want=01020304", data_m); end
    send(8'h05, 1'b0); send(8'h06, 1'b0); send(8'h07, 1'b0);
    in_valid = 1'b1; in_data = 8'h08;
    #1;
    total++; if (in_ready_m !== 1'b0) begin bad++; $display("FAIL bp_stall got=%b want=0", in_ready_m); end
    step(); step();
    total++; if (in_ready_m !== 1'b0) begin bad++; $display("FAIL bp_stall_hold got=%b want=0", in_ready_m); end
    total++; if (data_m !== 32'h01020304 || out_valid_m !== 1'b1) begin bad++; $display("FAIL bp_hold got=%h/%b want=01020304/1", data_m, out_valid_m); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready_m !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", in_ready_m); end
    step();
    in_valid = 1'b0;
    total++; if (data_m !== 32'h05060708 || out_valid_m !== 1'b1) begin bad++; $display("FAIL bp_second got=%h/%b want=05060708/1", data_m, out_valid_m); end
    step();
    total++; if (out_valid_m !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b want=0", out_valid_m); end
  endtask

  task automatic test_back_to_back();
    int words;
    words = 0;
    // in_last/in_data ignored without in_valid
    in_valid = 1'b0; in_last = 1'b1; in_data = 8'hFF;
    step();
    in_last = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(8'hA0 + 8'(i), 1'b0);
      if (out_valid_m === 1'b1) words++;
      in_valid = 1'b1;
      if (i == 3) begin
        total++; if (data_m !== 32'hA0A1A2A3) begin bad++; $display("FAIL b2b_w0 got=%h want=a0a1a2a3", data_m); end
      end
      if (i == 7) begin
        total++; if (data_m !== 32'hA4A5A6A7) begin bad++; $display("FAIL b2b_w1 got=%h want=a4a5a6a7", data_m); end
      end
    end
    in_valid = 1'b0;
    total++; if (words != 2) begin bad++; $display("FAIL b2b_words got=%0d want=2", words); end
    step();
  endtask

  task automatic test_reset_mid_word();
    int early;
    early = 0;
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b0);
    reset = 1'b0;
    #1;
    total++; if (out_valid_m !== 1'b0 || data_m !== 32'h0 || keep_m !== 4'b0) begin bad++; $display("FAIL mid_reset_out got=%b/%h/%b want=0/0/0", out_valid_m, data_m, keep_m); end
    step();
    reset = 1'b1;
    send(8'h01, 1'b0); if (out_valid_m !== 1'b0) early++;
    send(8'h02, 1'b0); if (out_valid_m !== 1'b0) early++;
    send(8'h03, 1'b0); if (out_valid_m !== 1'b0) early++;
    total++; if (early != 0) begin bad++; $display("FAIL mid_reset_early got=%0d want=0", early); end
    send(8'h04, 1'b0);
    total++; if (data_m !== 32'h01020304 || out_valid_m !== 1'b1) begin bad++; $display("FAIL mid_reset_word got=%h/%b want=01020304/1", data_m, out_valid_m); end
    step();
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial_flush();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
